// File: rtl/muldiv_unit_if.sv
// Request/response bundle between an issuing pipeline and muldiv_unit.
// The requester drives the operation; the unit returns status and register-file write signals.
interface muldiv_unit_if;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [4:0]  rd_addr;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [4:0]  wr_addr;
  logic        wr_en;

  modport master (
    output start, funct3, op_a, op_b, rd_addr,
    input  busy, done, result, wr_addr, wr_en
  );

  modport slave (
    input  start, funct3, op_a, op_b, rd_addr,
    output busy, done, result, wr_addr, wr_en
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: 32-cycle shift-add multiply and restoring divide.
// Optional macro MULDIV_FAST_MUL_EN swaps in a single-cycle combinational multiplier.
module muldiv_unit (
  input  logic         clk,
  input  logic         reset,
  muldiv_unit_if.slave mdu
);

  localparam logic [2:0] F_MUL    = 3'b000;
  localparam logic [2:0] F_MULH   = 3'b001;
  localparam logic [2:0] F_MULHSU = 3'b010;
  localparam logic [2:0] F_MULHU  = 3'b011;
  localparam logic [2:0] F_DIV    = 3'b100;
  localparam logic [2:0] F_DIVU   = 3'b101;
  localparam logic [2:0] F_REM    = 3'b110;
  localparam logic [2:0] F_REMU   = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_e;

  state_e      state_q;
  logic [4:0]  cnt_q;
  logic [2:0]  op_q;
  logic [4:0]  rd_q;
  logic        neg_q;
  logic [31:0] b_q;
  logic [64:0] acc_q;
  logic        busy_q;
  logic        done_q;
  logic        wr_en_q;
  logic [31:0] result_q;
  logic [4:0]  wr_addr_q;

  // Request decode, evaluated only while IDLE
  logic        in_is_div;
  logic        in_a_signed;
  logic        in_b_signed;
  logic        in_a_neg;
  logic        in_b_neg;
  logic        in_neg;
  logic [31:0] in_a_mag;
  logic [31:0] in_b_mag;
  logic        in_div0;
  logic        in_ovf;
  logic        short_path;
  logic [31:0] short_result;

`ifdef MULDIV_FAST_MUL_EN
  logic signed [65:0] fast_a;
  logic signed [65:0] fast_b;
  logic signed [65:0] fast_prod;
`endif

  // NOTE: every always_comb output gets a default before any branch, so no latch is inferred.
  always_comb begin
    in_is_div   = mdu.funct3[2];
    in_a_signed = (mdu.funct3 == F_MULH) || (mdu.funct3 == F_MULHSU) ||
                  (mdu.funct3 == F_DIV)  || (mdu.funct3 == F_REM);
    in_b_signed = (mdu.funct3 == F_MULH) || (mdu.funct3 == F_DIV) ||
                  (mdu.funct3 == F_REM);
    in_a_neg    = in_a_signed && mdu.op_a[31];
    in_b_neg    = in_b_signed && mdu.op_b[31];
    in_a_mag    = in_a_neg ? (32'd0 - mdu.op_a) : mdu.op_a;
    in_b_mag    = in_b_neg ? (32'd0 - mdu.op_b) : mdu.op_b;
    // Remainder takes the dividend's sign; product and quotient take the XOR
    in_neg      = (in_is_div && mdu.funct3[1]) ? in_a_neg : (in_a_neg ^ in_b_neg);

    in_div0     = in_is_div && (mdu.op_b == 32'd0);
    in_ovf      = in_is_div && !mdu.funct3[0] &&
                  (mdu.op_a == 32'h8000_0000) && (mdu.op_b == 32'hFFFF_FFFF);

    short_path   = 1'b0;
    short_result = 32'd0;
    if (in_div0) begin
      short_path   = 1'b1;
      short_result = mdu.funct3[1] ? mdu.op_a : 32'hFFFF_FFFF;
    end else if (in_ovf) begin
      short_path   = 1'b1;
      short_result = mdu.funct3[1] ? 32'd0 : 32'h8000_0000;
    end
`ifdef MULDIV_FAST_MUL_EN
    fast_a    = {{34{in_a_signed && mdu.op_a[31]}}, mdu.op_a};
    fast_b    = {{34{in_b_signed && mdu.op_b[31]}}, mdu.op_b};
    fast_prod = fast_a * fast_b;
    if (!in_is_div) begin
      short_path   = 1'b1;
      short_result = (mdu.funct3 == F_MUL) ? fast_prod[31:0] : fast_prod[63:32];
    end
`endif
  end

  // One iteration step and final result formatting for the CALC state
  logic [32:0] mul_sum;
  logic [64:0] mul_next;
  logic [64:0] div_shift;
  logic [33:0] div_diff;
  logic [64:0] div_next;
  logic [64:0] acc_d;
  logic [63:0] prod_s;
  logic [31:0] quo_s;
  logic [31:0] rem_s;
  logic [31:0] calc_result;

  always_comb begin
    // Shift-add: accumulate multiplicand into the high half, shift the pair right
    mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, b_q} : 33'd0);
    mul_next  = {1'b0, mul_sum, acc_q[31:1]};

    // Restoring divide: {remainder, dividend} shifts left, quotient bits enter at bit 0
    div_shift = {acc_q[63:0], 1'b0};
    div_diff  = {1'b0, div_shift[64:32]} - {2'b00, b_q};
    div_next  = div_diff[33] ? div_shift : {div_diff[32:0], div_shift[31:1], 1'b1};

    acc_d     = op_q[2] ? div_next : mul_next;

    prod_s    = neg_q ? (64'd0 - acc_d[63:0]) : acc_d[63:0];
    quo_s     = neg_q ? (32'd0 - acc_d[31:0]) : acc_d[31:0];
    rem_s     = neg_q ? (32'd0 - acc_d[63:32]) : acc_d[63:32];

    calc_result = prod_s[31:0];
    case (op_q)
      F_MUL:                      calc_result = prod_s[31:0];
      F_MULH, F_MULHSU, F_MULHU:  calc_result = prod_s[63:32];
      F_DIV, F_DIVU:              calc_result = quo_s;
      F_REM, F_REMU:              calc_result = rem_s;
      default:                    calc_result = prod_s[31:0];
    endcase
  end

  // NOTE: all state below is sequential and updated with non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= 5'd0;
      op_q      <= 3'd0;
      rd_q      <= 5'd0;
      neg_q     <= 1'b0;
      b_q       <= 32'd0;
      acc_q     <= 65'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      result_q  <= 32'd0;
      wr_addr_q <= 5'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q  <= 1'b0;
          wr_en_q <= 1'b0;
          if (mdu.start) begin
            op_q   <= mdu.funct3;
            rd_q   <= mdu.rd_addr;
            neg_q  <= in_neg;
            b_q    <= in_b_mag;
            acc_q  <= {33'd0, in_a_mag};
            cnt_q  <= 5'd0;
            busy_q <= 1'b1;
            if (short_path) begin
              state_q   <= S_DONE;
              done_q    <= 1'b1;
              result_q  <= short_result;
              wr_addr_q <= mdu.rd_addr;
              wr_en_q   <= (mdu.rd_addr != 5'd0);
            end else begin
              state_q <= S_CALC;
            end
          end
        end

        S_CALC: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            state_q   <= S_DONE;
            done_q    <= 1'b1;
            result_q  <= calc_result;
            wr_addr_q <= rd_q;
            wr_en_q   <= (rd_q != 5'd0);
          end
        end

        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          wr_en_q <= 1'b0;
        end

        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          wr_en_q <= 1'b0;
        end
      endcase
    end
  end

  assign mdu.busy    = busy_q;
  assign mdu.done    = done_q;
  assign mdu.result  = result_q;
  assign mdu.wr_addr = wr_addr_q;
  assign mdu.wr_en   = wr_en_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: stimulus pushes expected responses, a monitor pops on done.
// Latency expectations follow MULDIV_FAST_MUL_EN when it is defined for the build.
module tb_muldiv_unit;

  localparam logic [2:0] F_MUL    = 3'b000;
  localparam logic [2:0] F_MULH   = 3'b001;
  localparam logic [2:0] F_MULHSU = 3'b010;
  localparam logic [2:0] F_MULHU  = 3'b011;
  localparam logic [2:0] F_DIV    = 3'b100;
  localparam logic [2:0] F_DIVU   = 3'b101;
  localparam logic [2:0] F_REM    = 3'b110;
  localparam logic [2:0] F_REMU   = 3'b111;

  localparam int DIV_LAT  = 33;
  localparam int FAST_LAT = 1;
`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT  = 1;
`else
  localparam int MUL_LAT  = 33;
`endif

  typedef struct {
    logic [31:0] res;
    logic [4:0]  wa;
    logic        we;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t sb_q[$];

  muldiv_unit_if mdu ();

  muldiv_unit dut (
    .clk   (clk),
    .reset (reset),
    .mdu   (mdu)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every done must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (!reset && mdu.done === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done at cycle %0d with result 0x%08h expected no done",
                 cyc, mdu.result);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("result",  mdu.result, e.res);
        check("wr_addr", {27'd0, mdu.wr_addr}, {27'd0, e.wa});
        check("wr_en",   {31'd0, mdu.wr_en}, {31'd0, e.we});
        check("done_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic drive(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd);
    mdu.start   = 1'b1;
    mdu.funct3  = f;
    mdu.op_a    = a;
    mdu.op_b    = b;
    mdu.rd_addr = rd;
  endtask

  // Presents a request for exactly one rising edge; optionally records its expected response
  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] exp_res, input int lat,
                       input bit push);
    @(negedge clk);
    drive(f, a, b, rd);
    if (push) sb_q.push_back(exp_t'{res: exp_res, wa: rd, we: (rd != 5'd0), cyc: cyc + lat});
    @(negedge clk);
    mdu.start = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while ((mdu.busy === 1'b1 || sb_q.size() != 0) && n < 80) begin
      @(negedge clk);
      n++;
    end
    if (n >= 80) begin
      checks++;
      errors++;
      $display("FAIL timeout: got busy=%0b pending=%0d expected idle within 80 cycles",
               mdu.busy, sb_q.size());
      sb_q.delete();
    end
  endtask

  initial begin
    reset       = 1'b1;
    mdu.start   = 1'b0;
    mdu.funct3  = 3'd0;
    mdu.op_a    = 32'd0;
    mdu.op_b    = 32'd0;
    mdu.rd_addr = 5'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    check("reset_busy",    {31'd0, mdu.busy}, 32'd0);
    check("reset_done",    {31'd0, mdu.done}, 32'd0);
    check("reset_wr_en",   {31'd0, mdu.wr_en}, 32'd0);
    check("reset_result",  mdu.result, 32'd0);
    check("reset_wr_addr", {27'd0, mdu.wr_addr}, 32'd0);

    // Directed vectors: op, a, b, rd, expected result, latency
    issue(F_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5,  32'hFFFF_FFFE, MUL_LAT, 1); wait_idle();
    issue(F_DIV,    32'hFFFF_FFF9, 32'd2,         5'd1,  32'hFFFF_FFFD, DIV_LAT, 1); wait_idle();
    issue(F_REM,    32'hFFFF_FFF9, 32'd2,         5'd2,  32'hFFFF_FFFF, DIV_LAT, 1); wait_idle();
    issue(F_MUL,    32'hFFFF_FFF9, 32'd2,         5'd6,  32'hFFFF_FFF2, MUL_LAT, 1); wait_idle();
    issue(F_DIVU,   32'd5,         32'd0,         5'd7,  32'hFFFF_FFFF, FAST_LAT, 1); wait_idle();
    issue(F_REMU,   32'd5,         32'd0,         5'd8,  32'd5,         FAST_LAT, 1); wait_idle();
    issue(F_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 5'd9,  32'h8000_0000, FAST_LAT, 1); wait_idle();
    issue(F_REM,    32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 32'd0,         FAST_LAT, 1); wait_idle();
    issue(F_MUL,    32'd3,         32'd4,         5'd0,  32'd12,        MUL_LAT, 1); wait_idle();
    issue(F_MULH,   32'h8000_0000, 32'h8000_0000, 5'd11, 32'h4000_0000, MUL_LAT, 1); wait_idle();
    issue(F_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd12, 32'hFFFF_FFFF, MUL_LAT, 1); wait_idle();
    issue(F_REMU,   32'd100,       32'd7,         5'd13, 32'd2,         DIV_LAT, 1); wait_idle();
    issue(F_DIV,    32'd7,         32'hFFFF_FFFE, 5'd14, 32'hFFFF_FFFD, DIV_LAT, 1); wait_idle();
    issue(F_REM,    32'd7,         32'hFFFF_FFFE, 5'd15, 32'd1,         DIV_LAT, 1); wait_idle();

    // A second start while busy is dropped; only the DIVU completes
    issue(F_DIVU, 32'd100, 32'd7, 5'd3, 32'd14, DIV_LAT, 1);
    repeat (3) @(negedge clk);
    drive(F_MUL, 32'd3, 32'd3, 5'd20);
    check("busy_during_calc", {31'd0, mdu.busy}, 32'd1);
    @(negedge clk);
    mdu.start = 1'b0;
    wait_idle();

    // Result and write address hold after done
    repeat (3) @(negedge clk);
    check("hold_result",  mdu.result, 32'd14);
    check("hold_wr_addr", {27'd0, mdu.wr_addr}, 32'd3);
    check("hold_done",    {31'd0, mdu.done}, 32'd0);

    // start held into the DONE cycle of a fast-path op must not launch a second op
    @(negedge clk);
    drive(F_DIVU, 32'd9, 32'd0, 5'd4);
    sb_q.push_back(exp_t'{res: 32'hFFFF_FFFF, wa: 5'd4, we: 1'b1, cyc: cyc + FAST_LAT});
    repeat (2) @(negedge clk);
    mdu.start = 1'b0;
    wait_idle();
    repeat (3) @(negedge clk);

    // Reset mid-divide aborts the operation without a done
    issue(F_DIV, 32'd1000, 32'd3, 5'd17, 32'd0, DIV_LAT, 0);
    repeat (8) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy",   {31'd0, mdu.busy}, 32'd0);
    check("abort_result", mdu.result, 32'd0);
    check("abort_done",   {31'd0, mdu.done}, 32'd0);
    repeat (40) @(negedge clk);
    check("abort_quiet_busy", {31'd0, mdu.busy}, 32'd0);

    // Unit is usable again after the abort
    issue(F_DIVU, 32'd100, 32'd7, 5'd18, 32'd14, DIV_LAT, 1);
    wait_idle();

    check("scoreboard_empty", sb_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
